// File: rtl/axis_source_arbiter_pkg.sv
// Shared audio-stream definitions: arbiter state encoding and the common sample width
// used by the arbiter, I2S and volume blocks.
package axis_source_arbiter_pkg;

  localparam int unsigned AUDIO_DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ALIGN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/axis_frame_phase.sv
// Per-source stereo frame phase tracker: phase=0 means the next accepted beat is a left sample.
module axis_frame_phase
  import axis_source_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic beat,
  input  logic last,
  output logic phase
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
    end else if (beat) begin
      phase <= !last;
    end
  end

endmodule

// File: rtl/axis_source_arbiter.sv
// Two-input AXI-Stream stereo source selector; switches only on frame boundaries and
// continuously drains (and counts) beats from the source that is not forwarded.
module axis_source_arbiter
  import axis_source_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AUDIO_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  axis_clk,
  input  logic                  axis_resetn,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] s0_axis_data,
  input  logic                  s0_axis_valid,
  output logic                  s0_axis_ready,
  input  logic                  s0_axis_last,
  input  logic [DATA_WIDTH-1:0] s1_axis_data,
  input  logic                  s1_axis_valid,
  output logic                  s1_axis_ready,
  input  logic                  s1_axis_last,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic                  active_src,
  output logic                  switching,
  output logic [CNT_WIDTH-1:0]  discard_cnt
);

  arb_state_t state, state_nxt;
  logic cur, cur_nxt;
  logic ph0, ph1;
  logic load_ok, fwd_ready;
  logic acc0, acc1;
  logic cur_acc, cur_last, new_acc, ph_cur, ph_new;
  logic [DATA_WIDTH-1:0] cur_data;

  assign load_ok   = !m_axis_valid || m_axis_ready;
  assign fwd_ready = (state != ALIGN) && load_ok;

  // Readies are gated by reset so neither source can handshake while held in reset.
  assign s0_axis_ready = axis_resetn && (cur ? 1'b1 : fwd_ready);
  assign s1_axis_ready = axis_resetn && (cur ? fwd_ready : 1'b1);

  assign acc0 = s0_axis_valid && s0_axis_ready;
  assign acc1 = s1_axis_valid && s1_axis_ready;

  assign cur_acc  = cur ? acc1 : acc0;
  assign cur_last = cur ? s1_axis_last : s0_axis_last;
  assign cur_data = cur ? s1_axis_data : s0_axis_data;
  assign new_acc  = cur ? acc0 : acc1;
  assign ph_cur   = cur ? ph1 : ph0;
  assign ph_new   = cur ? ph0 : ph1;

  axis_frame_phase u_phase0 (
    .clk   (axis_clk),
    .rst_n (axis_resetn),
    .beat  (acc0),
    .last  (s0_axis_last),
    .phase (ph0)
  );

  axis_frame_phase u_phase1 (
    .clk   (axis_clk),
    .rst_n (axis_resetn),
    .beat  (acc1),
    .last  (s1_axis_last),
    .phase (ph1)
  );

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    unique case (state)
      RUN: begin
        if (sel != cur) begin
          // A request landing on the closing beat of a frame skips DRAIN entirely.
          if ((!ph_cur && !cur_acc) || (cur_acc && cur_last)) state_nxt = ALIGN;
          else                                                state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (sel == cur)                state_nxt = RUN;
        else if (cur_acc && cur_last)  state_nxt = ALIGN;
      end
      ALIGN: begin
        if (sel == cur) begin
          state_nxt = RUN;
        end else if (!ph_new && !new_acc) begin
          cur_nxt   = !cur;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state        <= RUN;
      cur          <= 1'b0;
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      m_axis_last  <= 1'b0;
      discard_cnt  <= '0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      if (cur_acc) begin
        m_axis_valid <= 1'b1;
        m_axis_data  <= cur_data;
        m_axis_last  <= cur_last;
      end else if (m_axis_ready) begin
        m_axis_valid <= 1'b0;
      end
      if (new_acc && (discard_cnt != '1)) begin
        discard_cnt <= discard_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign active_src = cur;
  assign switching  = (state != RUN);

endmodule

// File: tb/tb_axis_source_arbiter.sv
// Directed bench for axis_source_arbiter; a second instance with a 4-bit counter shares
// the stimulus to exercise discard counter saturation.
module tb_axis_source_arbiter;

  localparam int unsigned DW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sel;
  logic [DW-1:0] s0_data, s1_data;
  logic          s0_valid, s1_valid, s0_last, s1_last;
  logic          m_ready;

  logic          s0_ready, s1_ready, m_valid, m_last, active_src, switching;
  logic [DW-1:0] m_data;
  logic [15:0]   discard_cnt;

  logic          sat_s0_ready, sat_s1_ready, sat_m_valid, sat_m_last, sat_active, sat_switching;
  logic [DW-1:0] sat_m_data;
  logic [3:0]    sat_discard;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  axis_source_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .axis_clk(clk), .axis_resetn(rst_n), .sel(sel),
    .s0_axis_data(s0_data), .s0_axis_valid(s0_valid), .s0_axis_ready(s0_ready), .s0_axis_last(s0_last),
    .s1_axis_data(s1_data), .s1_axis_valid(s1_valid), .s1_axis_ready(s1_ready), .s1_axis_last(s1_last),
    .m_axis_data(m_data), .m_axis_valid(m_valid), .m_axis_ready(m_ready), .m_axis_last(m_last),
    .active_src(active_src), .switching(switching), .discard_cnt(discard_cnt)
  );

  axis_source_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_sat (
    .axis_clk(clk), .axis_resetn(rst_n), .sel(sel),
    .s0_axis_data(s0_data), .s0_axis_valid(s0_valid), .s0_axis_ready(sat_s0_ready), .s0_axis_last(s0_last),
    .s1_axis_data(s1_data), .s1_axis_valid(s1_valid), .s1_axis_ready(sat_s1_ready), .s1_axis_last(s1_last),
    .m_axis_data(sat_m_data), .m_axis_valid(sat_m_valid), .m_axis_ready(m_ready), .m_axis_last(sat_m_last),
    .active_src(sat_active), .switching(sat_switching), .discard_cnt(sat_discard)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [DW-1:0] d0, input logic l0,
                       input logic v1, input logic [DW-1:0] d1, input logic l1);
    s0_valid = v0; s0_data = d0; s0_last = l0;
    s1_valid = v1; s1_data = d1; s1_last = l1;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [DW-1:0] d, input logic l);
    check_vec({tag, "_valid"}, 32'(m_valid), 32'(v));
    if (v) begin
      check_vec({tag, "_data"}, 32'(m_data), 32'(d));
      check_vec({tag, "_last"}, 32'(m_last), 32'(l));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_vec({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check_vec({tag, "_m_data"}, 32'(m_data), 32'd0);
    check_vec({tag, "_m_last"}, 32'(m_last), 32'd0);
    check_vec({tag, "_s0_ready"}, 32'(s0_ready), 32'd0);
    check_vec({tag, "_s1_ready"}, 32'(s1_ready), 32'd0);
    check_vec({tag, "_active"}, 32'(active_src), 32'd0);
    check_vec({tag, "_switching"}, 32'(switching), 32'd0);
    check_vec({tag, "_discard"}, 32'(discard_cnt), 32'd0);
    check_vec({tag, "_sat_discard"}, 32'(sat_discard), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; sel = 1'b0; m_ready = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    check_reset_vals(tag);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- reset and plain forwarding on source 0 ----
    do_reset("rst1");
    drive(1'b1, 24'h000100, 1'b0, 1'b1, 24'h000111, 1'b0);
    check_vec("t1_s0_ready", 32'(s0_ready), 32'd1);
    check_vec("t1_s1_ready", 32'(s1_ready), 32'd1);
    tick();
    expect_out("t1_L", 1'b1, 24'h000100, 1'b0);
    check_vec("t1_disc1", 32'(discard_cnt), 32'd1);
    drive(1'b1, 24'h000200, 1'b1, 1'b1, 24'h000122, 1'b1);
    check_vec("t1_s1_ready_b", 32'(s1_ready), 32'd1);
    tick();
    expect_out("t1_R", 1'b1, 24'h000200, 1'b1);
    check_vec("t1_disc2", 32'(discard_cnt), 32'd2);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    expect_out("t1_idle", 1'b0, '0, 1'b0);
    check_vec("t1_active", 32'(active_src), 32'd0);

    // ---- switch 0 -> 1 after source 0's left beat ----
    drive(1'b1, 24'h000300, 1'b0, 1'b0, '0, 1'b0);
    tick();
    expect_out("t2_L0", 1'b1, 24'h000300, 1'b0);
    sel = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    check_vec("t2_switching_drain", 32'(switching), 32'd1);
    check_vec("t2_active_drain", 32'(active_src), 32'd0);
    drive(1'b1, 24'h000400, 1'b1, 1'b1, 24'h000500, 1'b0);
    check_vec("t2_s0_ready_drain", 32'(s0_ready), 32'd1);
    tick();
    expect_out("t2_R0", 1'b1, 24'h000400, 1'b1);
    check_vec("t2_disc3", 32'(discard_cnt), 32'd3);
    drive(1'b1, 24'h000999, 1'b0, 1'b1, 24'h000501, 1'b1);
    check_vec("t2_align_s0_ready", 32'(s0_ready), 32'd0);
    check_vec("t2_align_s1_ready", 32'(s1_ready), 32'd1);
    check_vec("t2_align_switching", 32'(switching), 32'd1);
    tick();
    expect_out("t2_align_out", 1'b0, '0, 1'b0);
    check_vec("t2_disc4", 32'(discard_cnt), 32'd4);
    check_vec("t2_active_align", 32'(active_src), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    check_vec("t2_active_new", 32'(active_src), 32'd1);
    check_vec("t2_switching_done", 32'(switching), 32'd0);
    drive(1'b1, 24'h000700, 1'b0, 1'b1, 24'h000600, 1'b0);
    check_vec("t2_s0_ready_disc", 32'(s0_ready), 32'd1);
    check_vec("t2_s1_ready_fwd", 32'(s1_ready), 32'd1);
    tick();
    expect_out("t2_L1", 1'b1, 24'h000600, 1'b0);
    check_vec("t2_disc5", 32'(discard_cnt), 32'd5);
    drive(1'b0, '0, 1'b0, 1'b1, 24'h000601, 1'b1);
    tick();
    expect_out("t2_R1", 1'b1, 24'h000601, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    expect_out("t2_idle", 1'b0, '0, 1'b0);

    // ---- one-cycle sel pulse mid-frame: no switch ----
    do_reset("rst2");
    drive(1'b1, 24'h000810, 1'b0, 1'b0, '0, 1'b0);
    tick();
    expect_out("t3_L", 1'b1, 24'h000810, 1'b0);
    sel = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    check_vec("t3_switching_pulse", 32'(switching), 32'd1);
    sel = 1'b0;
    drive(1'b1, 24'h000820, 1'b1, 1'b0, '0, 1'b0);
    tick();
    expect_out("t3_R", 1'b1, 24'h000820, 1'b1);
    check_vec("t3_switching_after", 32'(switching), 32'd0);
    check_vec("t3_active", 32'(active_src), 32'd0);
    drive(1'b1, 24'h000830, 1'b0, 1'b0, '0, 1'b0);
    tick();
    expect_out("t3_L2", 1'b1, 24'h000830, 1'b0);

    // ---- backpressure for 5 cycles ----
    m_ready = 1'b0;
    drive(1'b1, 24'h000840, 1'b1, 1'b0, '0, 1'b0);
    check_vec("t4_s0_ready_bp", 32'(s0_ready), 32'd0);
    check_vec("t4_s1_ready_bp", 32'(s1_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out($sformatf("t4_hold%0d", i), 1'b1, 24'h000830, 1'b0);
      check_vec($sformatf("t4_s0_ready%0d", i), 32'(s0_ready), 32'd0);
    end
    m_ready = 1'b1;
    #1;
    check_vec("t4_s0_ready_rel", 32'(s0_ready), 32'd1);
    tick();
    expect_out("t4_R", 1'b1, 24'h000840, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    expect_out("t4_idle", 1'b0, '0, 1'b0);

    // ---- discard counter saturation ----
    do_reset("rst3");
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, '0, 1'b0, 1'b1, 24'(i), i[0]);
      tick();
    end
    check_vec("t5_sat", 32'(sat_discard), 32'hF);
    check_vec("t5_wide", 32'(discard_cnt), 32'd20);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0, 1'b1, 24'h0000AA, 1'b1);
      tick();
    end
    check_vec("t5_sat_hold", 32'(sat_discard), 32'hF);
    check_vec("t5_wide_more", 32'(discard_cnt), 32'd23);

    // ---- reset asserted during DRAIN with output valid ----
    drive(1'b1, 24'h000A10, 1'b0, 1'b0, '0, 1'b0);
    tick();
    expect_out("t6_L", 1'b1, 24'h000A10, 1'b0);
    m_ready = 1'b0;
    sel = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    check_vec("t6_switching", 32'(switching), 32'd1);
    expect_out("t6_held", 1'b1, 24'h000A10, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_rst");
    tick();
    rst_n = 1'b1;
    sel = 1'b0;
    m_ready = 1'b1;
    drive(1'b1, 24'h000A20, 1'b0, 1'b0, '0, 1'b0);
    tick();
    expect_out("t6_L_after", 1'b1, 24'h000A20, 1'b0);
    check_vec("t6_active", 32'(active_src), 32'd0);
    drive(1'b1, 24'h000A21, 1'b1, 1'b0, '0, 1'b0);
    tick();
    expect_out("t6_R_after", 1'b1, 24'h000A21, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_source_arbiter.md
Name: axis_source_arbiter

Overview:
- Selects one of two AXI-Stream stereo audio sources and forwards it to the downstream volume/I2S transmit path.
  - Source 0 is typically Line-In from the I2S2 receiver.
  - Source 1 is typically an on-chip tone/test generator.
- Source changes take effect only on stereo-frame boundaries, so L/R ordering on the output is never corrupted.
- The unselected source is continuously drained, so an upstream I2S receiver never stalls.

Parameters:
- DATA_WIDTH, 24, sample width of every data bus.
- CNT_WIDTH, 16, width of the saturating discard counter.

Ports:
- axis_clk  in  1  stream clock.
- axis_resetn  in  1  asynchronous active-low reset.
- sel  in  1  requested source (0 or 1); already synchronous to axis_clk.
- s0_axis_data  in  DATA_WIDTH  source 0 sample.
- s0_axis_valid  in  1  source 0 valid.
- s0_axis_ready  out  1  source 0 ready.
- s0_axis_last  in  1  source 0 frame end (high on the right-channel beat).
- s1_axis_data/valid/ready/last  same as s0, for source 1.
- m_axis_data  out  DATA_WIDTH  output sample.
- m_axis_valid  out  1  output valid.
- m_axis_ready  in  1  output ready.
- m_axis_last  out  1  output frame end.
- active_src  out  1  source currently forwarded.
- switching  out  1  high while in DRAIN or ALIGN.
- discard_cnt  out  CNT_WIDTH  count of discarded input beats; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release); all of the following hold while axis_resetn=0:
  - m_axis_valid=0, m_axis_data=0, m_axis_last=0.
  - s0_axis_ready=0, s1_axis_ready=0.
  - active_src=0, switching=0, discard_cnt=0.
  - State=RUN; both phase flags=0.
  - Reset mid-frame discards the output register contents without completing the frame.
- Handshakes:
  - A beat transfers when valid&&ready on the same rising edge.
  - m_axis_valid, once high, holds data and last stable until m_axis_ready.
- Output stage: one register.
  - load_ok = !m_axis_valid || m_axis_ready.
  - The forwarded source's ready equals load_ok; the other source's ready is 1.
  - Beats accepted from the unselected source are discarded, and each one increments discard_cnt.
  - Latency from input handshake to m_axis_valid is 1 cycle.
  - Full throughput is 1 beat/cycle when m_axis_ready is held high.
- Phase flags ph0, ph1:
  - On every accepted beat of source k: ph_k <= last ? 0 : 1.
  - ph_k=0 means the next beat is a left-channel (frame start).
- State machine; cur is the registered forwarded source (drives active_src):
  - RUN:
    - Forward cur.
    - If sel!=cur and ph_cur==0 and no cur beat is accepted this cycle: go to ALIGN.
    - Else if sel!=cur: go to DRAIN.
  - DRAIN:
    - Keep forwarding cur.
    - On acceptance of a cur beat with last=1: go to ALIGN.
    - If sel==cur again: go to RUN with no switch.
  - ALIGN:
    - No source is forwarded: cur's ready=0 and the other source's ready=1 (discard).
    - When ph_new==0 and no new-source beat is accepted this cycle: cur <= !cur, go to RUN. The first forwarded beat is then a left channel.
    - If sel==cur again: go to RUN.
- Simultaneous events:
  - A sel toggle on the same cycle as cur's last handshake goes directly to ALIGN.
  - discard_cnt increment and saturation: holds at 2^CNT_WIDTH-1.
- Misframing (last on two consecutive beats) is accepted as-is; the phase flag simply resets.
- The output register keeps draining to the sink in every state.

Decomposition:
- Shared audio stream package holds:
  - The state encoding enum (RUN, DRAIN, ALIGN).
  - The DATA_WIDTH default constant, also used by the I2S and volume blocks.
- One natural sub-module: axis_frame_phase, the per-source phase tracker. Instantiate it twice.
- The output register stays inline.

Test Plan:
- Reset, sel=0, source 0 sends L=0x000100 / R=0x000200 (last on R), m_axis_ready=1:
  - Output shows the same two beats, each 1 cycle after input, last on 0x000200.
  - s1_axis_ready=1 throughout; discard_cnt counts source 1 beats.
- sel 0->1 after source 0's L beat:
  - switching=1.
  - Source 0's R beat is still forwarded with last=1.
  - Source 1 beats are discarded until its frame boundary; then active_src=1.
  - Next output beat is source 1's L. No output frame has an odd beat count.
- sel pulses 0->1->0 for 1 cycle mid-frame: no switch, active_src stays 0, output sequence identical to the no-pulse run.
- Backpressure with m_axis_ready held 0 for 5 cycles while selected source is valid:
  - m_axis_valid stays 1 with data stable.
  - Selected source ready=0; unselected ready=1.
  - Resumes with no loss or duplication.
- discard_cnt saturation (CNT_WIDTH=4): 20 unselected beats -> discard_cnt=0xF and holds.
- Assert axis_resetn=0 during DRAIN with m_axis_valid=1:
  - All outputs immediately reach reset values, active_src=0.
  - After release, forwarding restarts on source 0 at its next frame boundary.
